// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: machine word width and instruction stride.
// No logic; constants only.
// No handshake; pure parameters.
package mips_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int PC_STEP    = 4;

endpackage

// File: rtl/incrementor_core.sv
// Constant adder one bit wider than the operand, giving sum and carry-out.
// Zero-cycle latency, purely combinational.
// No flow control; output follows input every delta.
module incrementor_core
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH,
    parameter int STEP  = PC_STEP
) (
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

    logic [WIDTH:0] full_sum;

    assign full_sum = {1'b0, operand} + STEP_EXT;
    assign sum      = full_sum[WIDTH-1:0];
    assign carry    = full_sum[WIDTH];

endmodule

// File: rtl/incrementor.sv
// PC incrementor: combinational operand+STEP with carry, plus enabled capture registers and a wrap flag.
// Combinational outputs zero-cycle; registered outputs one cycle after an en=1 edge.
// No backpressure; en=0 simply holds the registered state.
module incrementor
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH,
    parameter int STEP  = PC_STEP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] incrementor_In,
    input  logic             en,
    output logic [WIDTH-1:0] incrementor_Out,
    output logic             carry,
    output logic [WIDTH-1:0] incrementor_Out_reg,
    output logic             carry_reg,
    output logic             wrap_sticky
);

    // A step of zero or of a full word or more makes the adder meaningless.
    // For WIDTH >= 31 any positive int step already fits below 2^WIDTH.
    if (STEP < 1 || (WIDTH < 31 && STEP >= (1 << WIDTH))) begin : g_bad_step
        $error("incrementor: STEP=%0d out of range for WIDTH=%0d", STEP, WIDTH);
    end

    incrementor_core #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_core (
        .operand (incrementor_In),
        .sum     (incrementor_Out),
        .carry   (carry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            incrementor_Out_reg <= '0;
            carry_reg           <= 1'b0;
            wrap_sticky         <= 1'b0;
        end else if (en) begin
            incrementor_Out_reg <= incrementor_Out;
            carry_reg           <= carry;
            if (carry) begin
                wrap_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_incrementor.sv
// Directed bench for incrementor at WIDTH=32, STEP=4.
module tb_incrementor;

    logic        clk;
    logic        reset;
    logic [31:0] incrementor_In;
    logic        en;
    logic [31:0] incrementor_Out;
    logic        carry;
    logic [31:0] incrementor_Out_reg;
    logic        carry_reg;
    logic        wrap_sticky;

    int n_checks = 0;
    int n_fail   = 0;

    incrementor #(
        .WIDTH (32),
        .STEP  (4)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .incrementor_In      (incrementor_In),
        .en                  (en),
        .incrementor_Out     (incrementor_Out),
        .carry               (carry),
        .incrementor_Out_reg (incrementor_Out_reg),
        .carry_reg           (carry_reg),
        .wrap_sticky         (wrap_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: sim time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; incrementor_In = 32'h0000_0001;
        #2;
        n_checks++;
        if (incrementor_Out_reg !== 32'h0) begin
            n_fail++; $display("FAIL reset_out_reg: got %h, required %h", incrementor_Out_reg, 32'h0);
        end
        n_checks++;
        if (carry_reg !== 1'b0) begin
            n_fail++; $display("FAIL reset_carry_reg: got %b, required 0", carry_reg);
        end
        n_checks++;
        if (wrap_sticky !== 1'b0) begin
            n_fail++; $display("FAIL reset_sticky: got %b, required 0", wrap_sticky);
        end
        n_checks++;
        if (incrementor_Out !== 32'h0000_0005) begin
            n_fail++; $display("FAIL reset_comb_out: got %h, required %h", incrementor_Out, 32'h5);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        @(negedge clk);
        incrementor_In = 32'h0000_0001; en = 1'b1;
        #0;
        n_checks++;
        if (incrementor_Out !== 32'h0000_0005 || carry !== 1'b0) begin
            n_fail++; $display("FAIL basic_comb: got %h/%b, required 00000005/0", incrementor_Out, carry);
        end
        n_checks++;
        if (incrementor_Out_reg !== 32'h0) begin
            n_fail++; $display("FAIL basic_before_edge: got %h, required 00000000", incrementor_Out_reg);
        end
        @(posedge clk); #1;
        n_checks++;
        if (incrementor_Out_reg !== 32'h0000_0005 || carry_reg !== 1'b0) begin
            n_fail++; $display("FAIL basic_reg: got %h/%b, required 00000005/0", incrementor_Out_reg, carry_reg);
        end
        n_checks++;
        if (wrap_sticky !== 1'b0) begin
            n_fail++; $display("FAIL basic_sticky: got %b, required 0", wrap_sticky);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        incrementor_In = 32'hFFFF_FFFC; en = 1'b1;
        #1;
        n_checks++;
        if (incrementor_Out !== 32'h0 || carry !== 1'b1) begin
            n_fail++; $display("FAIL wrap_comb: got %h/%b, required 00000000/1", incrementor_Out, carry);
        end
        @(posedge clk); #1;
        n_checks++;
        if (incrementor_Out_reg !== 32'h0 || carry_reg !== 1'b1) begin
            n_fail++; $display("FAIL wrap_reg: got %h/%b, required 00000000/1", incrementor_Out_reg, carry_reg);
        end
        n_checks++;
        if (wrap_sticky !== 1'b1) begin
            n_fail++; $display("FAIL wrap_sticky: got %b, required 1", wrap_sticky);
        end
        @(negedge clk);
        incrementor_In = 32'hFFFF_FFFF;
        #1;
        n_checks++;
        if (incrementor_Out !== 32'h0000_0003 || carry !== 1'b1) begin
            n_fail++; $display("FAIL wrap_max: got %h/%b, required 00000003/1", incrementor_Out, carry);
        end
    endtask

    task automatic test_no_wrap();
        @(negedge clk);
        incrementor_In = 32'hFFFF_FFFB; en = 1'b1;
        #1;
        n_checks++;
        if (incrementor_Out !== 32'hFFFF_FFFF || carry !== 1'b0) begin
            n_fail++; $display("FAIL nowrap_comb: got %h/%b, required ffffffff/0", incrementor_Out, carry);
        end
        @(posedge clk); #1;
        n_checks++;
        if (incrementor_Out_reg !== 32'hFFFF_FFFF || carry_reg !== 1'b0) begin
            n_fail++; $display("FAIL nowrap_reg: got %h/%b, required ffffffff/0", incrementor_Out_reg, carry_reg);
        end
        n_checks++;
        if (wrap_sticky !== 1'b1) begin
            n_fail++; $display("FAIL sticky_holds: got %b, required 1", wrap_sticky);
        end
        @(negedge clk);
        incrementor_In = 32'h0040_0000;
        #1;
        n_checks++;
        if (incrementor_Out !== 32'h0040_0004 || carry !== 1'b0) begin
            n_fail++; $display("FAIL text_base: got %h/%b, required 00400004/0", incrementor_Out, carry);
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        incrementor_In = 32'h0000_0001; en = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        en = 1'b0; incrementor_In = 32'h0000_0010;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (incrementor_Out_reg !== 32'h0000_0005 || carry_reg !== 1'b0) begin
                n_fail++; $display("FAIL hold_reg[%0d]: got %h/%b, required 00000005/0", i, incrementor_Out_reg, carry_reg);
            end
            n_checks++;
            if (incrementor_Out !== 32'h0000_0014) begin
                n_fail++; $display("FAIL hold_comb[%0d]: got %h, required 00000014", i, incrementor_Out);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (incrementor_Out_reg !== 32'h0 || carry_reg !== 1'b0 || wrap_sticky !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got %h/%b/%b, required 00000000/0/0",
                               incrementor_Out_reg, carry_reg, wrap_sticky);
        end
        @(negedge clk);
        en = 1'b1; incrementor_In = 32'hFFFF_FFFC;
        @(posedge clk); #1;
        n_checks++;
        if (incrementor_Out_reg !== 32'h0 || carry_reg !== 1'b0 || wrap_sticky !== 1'b0) begin
            n_fail++; $display("FAIL reset_priority: got %h/%b/%b, required 00000000/0/0",
                               incrementor_Out_reg, carry_reg, wrap_sticky);
        end
        n_checks++;
        if (incrementor_Out !== 32'h0 || carry !== 1'b1) begin
            n_fail++; $display("FAIL reset_comb: got %h/%b, required 00000000/1", incrementor_Out, carry);
        end
    endtask

    task automatic test_after_reset();
        @(negedge clk);
        reset = 1'b0; en = 1'b0; incrementor_In = 32'hFFFF_FFFC;
        @(posedge clk); #1;
        n_checks++;
        if (carry_reg !== 1'b0 || wrap_sticky !== 1'b0) begin
            n_fail++; $display("FAIL disabled_carry: got %b/%b, required 0/0", carry_reg, wrap_sticky);
        end
        @(negedge clk);
        en = 1'b1; incrementor_In = 32'h0000_0100;
        @(posedge clk); #1;
        n_checks++;
        if (incrementor_Out_reg !== 32'h0000_0104 || carry_reg !== 1'b0 || wrap_sticky !== 1'b0) begin
            n_fail++; $display("FAIL first_capture: got %h/%b/%b, required 00000104/0/0",
                               incrementor_Out_reg, carry_reg, wrap_sticky);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vec [4];
        vec[0] = 32'h0000_0000;
        vec[1] = 32'h1234_5678;
        vec[2] = 32'h7FFF_FFFE;
        vec[3] = 32'hFFFF_FFFD;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            incrementor_In = vec[i];
            @(posedge clk); #1;
            n_checks++;
            if (incrementor_Out_reg !== vec[i] + 32'd4 || carry_reg !== (i == 3)) begin
                n_fail++; $display("FAIL b2b[%0d]: got %h/%b, required %h/%b", i,
                                   incrementor_Out_reg, carry_reg, vec[i] + 32'd4, (i == 3));
            end
        end
        n_checks++;
        if (wrap_sticky !== 1'b1) begin
            n_fail++; $display("FAIL b2b_sticky: got %b, required 1", wrap_sticky);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_no_wrap();
        test_hold();
        test_reset_mid();
        test_after_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
